// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited request issue, in-order response
// tracking, prefetch FIFO toward decode, and redirect with stale-response discard.
module fetch_unit #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_3000,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc4,
  output logic            err_resp
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = CW + OW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [31:0]     fifo_inst [DEPTH];
  logic [XLEN-1:0] fifo_pc   [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] pcq [MAX_OUTSTANDING];
  logic [QW-1:0]   pq_wr, pq_rd;
  logic [OW-1:0]   outstanding, discard;

  logic issue, resp_fire, resp_keep, push, pop;
  logic [SW-1:0] inflight;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Every slot the FIFO may eventually need is reserved at issue time, so a
  // response can always be accepted; discarded responses hold no slot.
  assign inflight  = SW'(count) + SW'(outstanding) - SW'(discard);
  assign imem_req_valid = rst && !redirect_valid &&
                          (outstanding < OW'(MAX_OUTSTANDING)) &&
                          (inflight < SW'(DEPTH));
  assign imem_req_addr = fetch_pc;

  assign issue     = imem_req_valid && imem_req_ready;
  assign resp_fire = imem_resp_valid && (outstanding != '0);
  assign resp_keep = resp_fire && (discard == '0);
  assign push      = resp_keep && !redirect_valid;
  assign pop       = out_valid && out_ready && !redirect_valid;

  assign out_valid = (count != '0);
  assign out_inst  = fifo_inst[rd_ptr];
  assign out_pc    = fifo_pc[rd_ptr];
  assign out_pc4   = out_pc + XLEN'(4);

  function automatic logic [QW-1:0] qnext(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= imem_resp_data;
      fifo_pc[wr_ptr]   <= pcq[pq_rd];
    end
    if (issue) pcq[pq_wr] <= fetch_pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pq_wr       <= '0;
      pq_rd       <= '0;
      outstanding <= '0;
      discard     <= '0;
      err_resp    <= 1'b0;
    end else begin
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        pq_wr    <= '0;
        pq_rd    <= '0;
        discard  <= outstanding - OW'(resp_fire);
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + XLEN'(4);
          pq_wr    <= qnext(pq_wr);
        end
        if (resp_keep) pq_rd <= qnext(pq_rd);
        if (resp_fire && (discard != '0)) discard <= discard - OW'(1);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      outstanding <= outstanding + OW'(issue) - OW'(resp_fire);
      if (imem_resp_valid && (outstanding == '0)) err_resp <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order variable-latency memory model, a
// per-cycle vector table for fill/drain, and hand sequences for redirects.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst, out_pc, out_pc4;
  logic        err_resp;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_pc4(out_pc4),
    .err_resp(err_resp)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; int p; } mreq_t;
  typedef struct { logic ordy; logic ev; logic [31:0] epc; logic erq; } vec_t;

  mreq_t mq[$];
  int    cyc = 0;
  int    lat = 1;
  bit    mem_en = 1'b1;
  bit    inj = 1'b0;
  int    nvec = 0;
  int    nerr = 0;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // In-order memory: a response appears lat cycles after acceptance, one per cycle.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) mq.delete();
      else begin
        if (imem_resp_valid && mem_en && mq.size() > 0) void'(mq.pop_front());
        if (imem_req_valid && imem_req_ready) mq.push_back('{a: imem_req_addr, p: cyc});
      end
      #2;
      if (mem_en) begin
        imem_resp_valid = rst && (mq.size() > 0) && (cyc >= mq[0].p + lat - 1);
        imem_resp_data  = (mq.size() > 0) ? f(mq[0].a) : 32'h0;
      end else begin
        imem_resp_valid = inj;
        imem_resp_data  = 32'hDEAD_BEEF;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0; inj = 1'b0; mem_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  vec_t        tv[16];
  bit          found, req_seen;
  int          lat_cnt;
  logic [31:0] exp_pc;

  initial begin
    // cycle index = cycles since reset release; lat=1, ready=1
    tv[0]  = '{1'b0, 1'b0, 32'h0,    1'b1};
    tv[1]  = '{1'b0, 1'b0, 32'h0,    1'b1};
    tv[2]  = '{1'b0, 1'b1, 32'h3000, 1'b1};
    tv[3]  = '{1'b0, 1'b1, 32'h3000, 1'b1};
    tv[4]  = '{1'b0, 1'b1, 32'h3000, 1'b0};
    tv[5]  = '{1'b0, 1'b1, 32'h3000, 1'b0};
    tv[6]  = '{1'b0, 1'b1, 32'h3000, 1'b0};
    tv[7]  = '{1'b0, 1'b1, 32'h3000, 1'b0};
    tv[8]  = '{1'b0, 1'b1, 32'h3000, 1'b0};
    tv[9]  = '{1'b0, 1'b1, 32'h3000, 1'b0};
    tv[10] = '{1'b1, 1'b1, 32'h3000, 1'b0};
    tv[11] = '{1'b1, 1'b1, 32'h3004, 1'b1};
    tv[12] = '{1'b1, 1'b1, 32'h3008, 1'b1};
    tv[13] = '{1'b1, 1'b1, 32'h300C, 1'b1};
    tv[14] = '{1'b1, 1'b1, 32'h3010, 1'b1};
    tv[15] = '{1'b1, 1'b1, 32'h3014, 1'b1};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_err", 32'(err_resp), 32'd0);

    // Fill with decode stalled, then drain at full rate.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst = 1'b1;
      out_ready = tv[i].ordy;
      #1;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tv[i].ev));
      chk($sformatf("v%0d_reqv", i), 32'(imem_req_valid), 32'(tv[i].erq));
      if (tv[i].ev) begin
        chk($sformatf("v%0d_pc", i), out_pc, tv[i].epc);
        chk($sformatf("v%0d_pc4", i), out_pc4, tv[i].epc + 32'd4);
        chk($sformatf("v%0d_inst", i), out_inst, f(tv[i].epc));
      end
    end

    // Redirect with two slow requests in flight.
    do_reset();
    lat = 5; out_ready = 1'b1;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h4003;
    #1;
    chk("redir_blocks_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk); redirect_valid = 1'b0;
    found = 1'b0; req_seen = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      #1;
      if (imem_req_valid && !req_seen) begin
        req_seen = 1'b1;
        chk("redir_req_addr", imem_req_addr, 32'h4000);
      end
      if (out_valid) found = 1'b1;
      else @(negedge clk);
    end
    chk("redir_found", 32'(found), 32'd1);
    chk("redir_pc", out_pc, 32'h4000);
    chk("redir_inst", out_inst, f(32'h4000));
    chk("redir_err", 32'(err_resp), 32'd0);

    // Redirect in the same cycle as a kept response and a decode pop.
    do_reset();
    lat = 2;
    @(negedge clk); rst = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      #1;
      if (out_valid && imem_resp_valid && mq.size() == 2) found = 1'b1;
      else @(negedge clk);
    end
    chk("coinc_found", 32'(found), 32'd1);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h5000;
    @(negedge clk); redirect_valid = 1'b0;
    #1;
    chk("flush_empty", 32'(out_valid), 32'd0);
    exp_pc = 32'h5000;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) begin
        chk("flush_seq_pc", out_pc, exp_pc);
        chk("flush_seq_inst", out_inst, f(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      @(negedge clk); #1;
    end
    chk("flush_progress", 32'(exp_pc >= 32'h5008), 32'd1);
    chk("flush_err", 32'(err_resp), 32'd0);

    // Redirect to the top of the address space; also measures redirect latency.
    do_reset();
    lat = 1; out_ready = 1'b1;
    @(negedge clk); rst = 1'b1;
    repeat (5) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    found = 1'b0; lat_cnt = 0;
    for (int k = 1; k <= 10 && !found; k++) begin
      @(negedge clk); redirect_valid = 1'b0;
      #1;
      if (out_valid) begin found = 1'b1; lat_cnt = k; end
    end
    chk("wrap_latency", 32'(lat_cnt), 32'd3);
    chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4_0", out_pc4, 32'h0000_0000);
    @(negedge clk); #1;
    chk("wrap_valid1", 32'(out_valid), 32'd1);
    chk("wrap_pc1", out_pc, 32'h0000_0000);
    chk("wrap_pc4_1", out_pc4, 32'h0000_0004);

    // Spurious response with nothing outstanding, then async reset mid-stream.
    do_reset();
    lat = 1;
    @(negedge clk); rst = 1'b1;
    repeat (8) @(negedge clk);
    mem_en = 1'b0; inj = 1'b1;
    @(negedge clk); inj = 1'b0;
    @(negedge clk); #1;
    chk("err_set", 32'(err_resp), 32'd1);
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk("err_fifo_valid", 32'(out_valid), 32'd1);
      chk("err_fifo_pc", out_pc, 32'h3000 + 32'(4 * j));
      @(negedge clk); #1;
    end
    out_ready = 1'b0;
    chk("err_fifo_pc_last", out_pc, 32'h300C);
    chk("err_sticky", 32'(err_resp), 32'd1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_req_valid", 32'(imem_req_valid), 32'd0);
    chk("async_err", 32'(err_resp), 32'd0);
    mem_en = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
